// File: rtl/fm_adapter_mc.sv
// FM carrier adapter: carrier / FM / carrier+FM phase increment generator with
// registered AXI-Stream output, full backpressure and valley-based period measurement.
module fm_adapter_mc #(
    parameter int unsigned S_AXIS_TDATA_WIDTH = 16,
    parameter int unsigned M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CARRIER_PINC_WIDTH = 32,
    parameter int unsigned PERIOD_WIDTH       = 24
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [1:0]                    mode,
    input  logic [4:0]                    shift_carrier,
    input  logic [CARRIER_PINC_WIDTH-1:0] phase_carrier,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] hysteresis,
    output logic                          switch_enable,
    output logic [PERIOD_WIDTH-1:0]       period,
    output logic                          period_valid,
    input  logic                          S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                          S_AXIS_tready,
    input  logic                          M_AXIS_tready,
    output logic                          M_AXIS_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    localparam int unsigned SW = S_AXIS_TDATA_WIDTH;
    localparam int unsigned MW = M_AXIS_TDATA_WIDTH;
    localparam int unsigned PW = PERIOD_WIDTH;
    localparam logic [PW-1:0] CNT_MAX = '1;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } slope_t;

    slope_t          state_q, state_d;
    logic [SW-1:0]   ext_q, ext_d;
    logic [PW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            primed_q, primed_d;
    logic            sw_q, sw_d;
    logic [PW-1:0]   period_q, period_d;
    logic            pv_q, pv_d;
    logic            tvalid_q, tvalid_d;
    logic [MW-1:0]   tdata_q, tdata_d;

    logic            fm_mode;
    logic            load;
    logic            hs;
    logic            valley;
    logic [SW-1:0]   u;
    logic [MW-1:0]   fm;
    logic [MW-1:0]   carrier;

    // Datapath decode: offset-binary sample, shifted FM term, handshake qualifiers
    assign fm_mode       = (mode == 2'd1) || (mode == 2'd2);
    assign u             = {~S_AXIS_tdata[SW-1], S_AXIS_tdata[SW-2:0]};
    assign fm            = MW'(u) >> shift_carrier;
    assign carrier       = MW'(phase_carrier);
    assign load          = ~tvalid_q | M_AXIS_tready;
    assign S_AXIS_tready = fm_mode ? load : 1'b1;
    assign hs            = fm_mode & S_AXIS_tvalid & load;
    assign cnt_inc       = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PW'(1);

    // Next-state logic for output register and slope detector
    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        sw_d     = sw_q;
        period_d = period_q;
        pv_d     = 1'b0;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        valley   = 1'b0;

        if (!fm_mode) begin
            if (load) begin
                tdata_d  = carrier;
                tvalid_d = 1'b1;
            end
            state_d  = DOWN;
            ext_d    = '1;
            cnt_d    = '0;
            primed_d = 1'b0;
            sw_d     = 1'b0;
        end else begin
            if (load) begin
                tvalid_d = hs;
                if (hs) begin
                    tdata_d = (mode == 2'd2) ? carrier + fm : fm;
                end
            end
            if (hs) begin
                cnt_d = cnt_inc;
                case (state_q)
                    DOWN: begin
                        if (u < ext_q) begin
                            ext_d = u;
                        end else if ((u - ext_q) > hysteresis) begin
                            state_d = UP;
                            ext_d   = u;
                            valley  = 1'b1;
                        end
                    end
                    UP: begin
                        if (u > ext_q) begin
                            ext_d = u;
                        end else if ((ext_q - u) > hysteresis) begin
                            state_d = DOWN;
                            ext_d   = u;
                        end
                    end
                    default: begin
                        state_d = DOWN;
                    end
                endcase
                if (valley) begin
                    sw_d = ~sw_q;
                    if (primed_q) begin
                        period_d = cnt_inc;
                        pv_d     = 1'b1;
                    end
                    cnt_d    = '0;
                    primed_d = 1'b1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= DOWN;
            ext_q    <= '1;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            sw_q     <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            sw_q     <= sw_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    assign switch_enable = sw_q;
    assign period        = period_q;
    assign period_valid  = pv_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign M_AXIS_tdata  = tdata_q;

endmodule
